// File: rtl/ppc_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppc_disp_pkg
// Brief    : Shared encodings for the ping-pong counter seven-segment display.
// Revision : 1.0
// ============================================================================
package ppc_disp_pkg;

    typedef enum logic [1:0] {
        SEL_D0 = 2'd0,
        SEL_D1 = 2'd1,
        SEL_D2 = 2'd2,
        SEL_D3 = 2'd3
    } digit_sel_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_UP_DEFAULT = 7'b1011100;
    localparam logic [6:0] GLYPH_DN_DEFAULT = 7'b1100011;

    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] anode_for(input digit_sel_e sel);
        logic [3:0] an;
        case (sel)
            SEL_D3:  an = AN_D3;
            SEL_D2:  an = AN_D2;
            SEL_D1:  an = AN_D1;
            default: an = AN_D0;
        endcase
        return an;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppc_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ppc_seg_decoder
// Brief    : Combinational BCD digit to active-low seven-segment decode.
// Revision : 1.0
// ============================================================================
module ppc_seg_decoder
    import ppc_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ppc_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : ppc_seg_display
// Brief    : 4-digit multiplexed display of ping-pong count and direction.
//            Optional macro PPC_SEG_ZERO_BLANK_EN blanks a leading zero.
// Revision : 1.0
// ============================================================================
module ppc_seg_display
    import ppc_disp_pkg::*;
#(
    parameter int unsigned SCAN_BITS = 17,
    parameter logic [6:0]  UP_GLYPH  = GLYPH_UP_DEFAULT,
    parameter logic [6:0]  DN_GLYPH  = GLYPH_DN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] count,
    input  logic       direction,
    input  logic       enable,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [3:0]           snap_count_q, snap_count_d;
    logic                 snap_dir_q, snap_dir_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic                 w_frame_end;
    digit_sel_e           w_sel;
    logic                 w_tens_one;
    logic [3:0]           w_ones;
    logic [3:0]           w_bcd;
    logic [6:0]           w_dec_seg;
    logic [6:0]           w_glyph;

    always_comb begin
        w_frame_end  = &scan_q;
        scan_d       = scan_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
        snap_count_d = w_frame_end ? count     : snap_count_q;
        snap_dir_d   = w_frame_end ? direction : snap_dir_q;
        frame_tick_d = w_frame_end;

        w_sel      = digit_sel_e'(scan_q[SCAN_BITS-1 -: 2]);
        // Binary to BCD for 0..15 needs a single compare-and-subtract
        w_tens_one = (snap_count_q >= 4'd10);
        w_ones     = w_tens_one ? (snap_count_q - 4'd10) : snap_count_q;
        w_glyph    = snap_dir_q ? UP_GLYPH : DN_GLYPH;

        w_bcd = 4'd0;
        case (w_sel)
            SEL_D3:  w_bcd = {3'b000, w_tens_one};
            SEL_D2:  w_bcd = w_ones;
            default: w_bcd = 4'd0;
        endcase
    end

    ppc_seg_decoder u_decoder (
        .i_bcd (w_bcd),
        .o_seg (w_dec_seg)
    );

    // Anode and segments are registered together so they always switch on the same edge
    always_comb begin
        seg_d = w_dec_seg;
        case (w_sel)
            SEL_D3: begin
`ifdef PPC_SEG_ZERO_BLANK_EN
                seg_d = w_tens_one ? w_dec_seg : SEG_BLANK;
`else
                seg_d = w_dec_seg;
`endif
            end
            SEL_D2:  seg_d = w_dec_seg;
            default: seg_d = w_glyph;
        endcase
        an_d = enable ? anode_for(w_sel) : AN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q       <= '0;
            snap_count_q <= 4'd0;
            snap_dir_q   <= 1'b1;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
        end else begin
            scan_q       <= scan_d;
            snap_count_q <= snap_count_d;
            snap_dir_q   <= snap_dir_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
